// File: rtl/operand_fetch.sv
// Operand fetch between decode and execute. It drives the register file read ports and forwards writebacks into both operands.
// Latency: a request accepted at edge E appears on out_valid after edge E+1. Throughput is one request per cycle.
// Back-pressure: S2 holds while out_ready is low, and in_ready drops once S1 is also occupied.
module operand_fetch #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_src1,
    input  logic [ADDR_WIDTH-1:0] in_src2,
    input  logic [ADDR_WIDTH-1:0] in_dst,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic [ADDR_WIDTH-1:0] rf_addr_rd1,
    output logic [ADDR_WIDTH-1:0] rf_addr_rd2,
    input  logic [WIDTH-1:0]      rf_rd1,
    input  logic [WIDTH-1:0]      rf_rd2,
    input  logic                  wb_enable,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_op1,
    output logic [WIDTH-1:0]      out_op2,
    output logic [ADDR_WIDTH-1:0] out_src1,
    output logic [ADDR_WIDTH-1:0] out_src2,
    output logic [ADDR_WIDTH-1:0] out_dst,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH-1:0] s1_src1_q, s1_src1_d;
    logic [ADDR_WIDTH-1:0] s1_src2_q, s1_src2_d;
    logic [ADDR_WIDTH-1:0] s1_dst_q, s1_dst_d;
    logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;
    logic                  s1_hit1_q, s1_hit1_d;
    logic                  s1_hit2_q, s1_hit2_d;
    logic [WIDTH-1:0]      s1_bdata1_q, s1_bdata1_d;
    logic [WIDTH-1:0]      s1_bdata2_q, s1_bdata2_d;

    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      out_op1_q, out_op1_d;
    logic [WIDTH-1:0]      out_op2_q, out_op2_d;
    logic [ADDR_WIDTH-1:0] out_src1_q, out_src1_d;
    logic [ADDR_WIDTH-1:0] out_src2_q, out_src2_d;
    logic [ADDR_WIDTH-1:0] out_dst_q, out_dst_d;
    logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

    logic             s2_free, s1_adv, s1_open, in_fire, s1_replay;
    logic             wb_hit_rd1, wb_hit_rd2;
    logic             wb_hit_s1_1, wb_hit_s1_2;
    logic             wb_hit_o1, wb_hit_o2;
    logic [WIDTH-1:0] fwd_op1, fwd_op2;

    always_comb begin
        s2_free     = !out_valid_q || out_ready;
        s1_adv      = s1_valid_q && s2_free;
        s1_open     = !s1_valid_q || s1_adv;
        in_ready    = reset && s1_open;
        in_fire     = in_valid && in_ready;
        s1_replay   = s1_valid_q && !s1_adv;
        // A stalled S1 re-issues its own read so that rf_rd tracks any later writes.
        rf_addr_rd1 = s1_open ? in_src1 : s1_src1_q;
        rf_addr_rd2 = s1_open ? in_src2 : s1_src2_q;
        wb_hit_rd1  = wb_enable && (wb_addr == rf_addr_rd1);
        wb_hit_rd2  = wb_enable && (wb_addr == rf_addr_rd2);
        wb_hit_s1_1 = wb_enable && (wb_addr == s1_src1_q);
        wb_hit_s1_2 = wb_enable && (wb_addr == s1_src2_q);
        wb_hit_o1   = wb_enable && (wb_addr == out_src1_q);
        wb_hit_o2   = wb_enable && (wb_addr == out_src2_q);
        // Newest value first: a write landing this edge, then a write missed by the read, then the RF.
        fwd_op1     = wb_hit_s1_1 ? wb_data : (s1_hit1_q ? s1_bdata1_q : rf_rd1);
        fwd_op2     = wb_hit_s1_2 ? wb_data : (s1_hit2_q ? s1_bdata2_q : rf_rd2);
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_src1_d   = s1_src1_q;
        s1_src2_d   = s1_src2_q;
        s1_dst_d    = s1_dst_q;
        s1_tag_d    = s1_tag_q;
        s1_hit1_d   = s1_hit1_q;
        s1_hit2_d   = s1_hit2_q;
        s1_bdata1_d = s1_bdata1_q;
        s1_bdata2_d = s1_bdata2_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_src1_d  = in_src1;
            s1_src2_d  = in_src2;
            s1_dst_d   = in_dst;
            s1_tag_d   = in_tag;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        // The RF returns the old value when a write coincides with a read, so that write is captured here.
        if (in_fire || s1_replay) begin
            s1_hit1_d   = wb_hit_rd1;
            s1_hit2_d   = wb_hit_rd2;
            s1_bdata1_d = wb_data;
            s1_bdata2_d = wb_data;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_op1_d   = out_op1_q;
        out_op2_d   = out_op2_q;
        out_src1_d  = out_src1_q;
        out_src2_d  = out_src2_q;
        out_dst_d   = out_dst_q;
        out_tag_d   = out_tag_q;
        if (s1_adv) begin
            out_valid_d = 1'b1;
            out_op1_d   = fwd_op1;
            out_op2_d   = fwd_op2;
            out_src1_d  = s1_src1_q;
            out_src2_d  = s1_src2_q;
            out_dst_d   = s1_dst_q;
            out_tag_d   = s1_tag_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            if (wb_hit_o1) out_op1_d = wb_data;
            if (wb_hit_o2) out_op2_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_src1_q   <= '0;
            s1_src2_q   <= '0;
            s1_dst_q    <= '0;
            s1_tag_q    <= '0;
            s1_hit1_q   <= 1'b0;
            s1_hit2_q   <= 1'b0;
            s1_bdata1_q <= '0;
            s1_bdata2_q <= '0;
            out_valid_q <= 1'b0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            out_src1_q  <= '0;
            out_src2_q  <= '0;
            out_dst_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_src1_q   <= s1_src1_d;
            s1_src2_q   <= s1_src2_d;
            s1_dst_q    <= s1_dst_d;
            s1_tag_q    <= s1_tag_d;
            s1_hit1_q   <= s1_hit1_d;
            s1_hit2_q   <= s1_hit2_d;
            s1_bdata1_q <= s1_bdata1_d;
            s1_bdata2_q <= s1_bdata2_d;
            out_valid_q <= out_valid_d;
            out_op1_q   <= out_op1_d;
            out_op2_q   <= out_op2_d;
            out_src1_q  <= out_src1_d;
            out_src2_q  <= out_src2_d;
            out_dst_q   <= out_dst_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op1   = out_op1_q;
    assign out_op2   = out_op2_q;
    assign out_src1  = out_src1_q;
    assign out_src2  = out_src2_q;
    assign out_dst   = out_dst_q;
    assign out_tag   = out_tag_q;

endmodule
